// File: rtl/zero_count_expander.sv
// rtl/zero_count_expander.sv - serial builder of a word with a requested count of LSB zero bits (optional checker: ZERO_EXP_SELFCHECK_EN)
module zero_count_expander #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] zero_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] number,
  output logic [WIDTH-1:0] led,
  output logic             ovf,
  output logic             chk_err
);

  typedef enum logic [1:0] {IDLE, BUILD, HOLD} state_t;

  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] index, index_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] number_nxt;
  logic             out_valid_nxt;
  logic             ovf_nxt;

  // Requests are only taken while idle, enabled and out of reset.
  assign in_ready = (state == IDLE) && enable && RST;

  // State register; reset aborts any build or held word.
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and datapath updates; index is one bit wider than a bit index so it can reach WIDTH.
  always_comb begin
    state_nxt     = state;
    index_nxt     = index;
    count_nxt     = count;
    number_nxt    = number;
    out_valid_nxt = out_valid;
    ovf_nxt       = ovf;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          count_nxt  = (zero_count > WIDTH_C) ? WIDTH_C : zero_count;
          ovf_nxt    = (zero_count > WIDTH_C);
          index_nxt  = '0;
          number_nxt = '1;
          state_nxt  = BUILD;
        end
      end
      BUILD: begin
        if (enable) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (CNT_W'(i) == index) number_nxt[i] = !(index < count);
          end
          index_nxt = index + CNT_W'(1);
          if (index == LAST_IDX) begin
            state_nxt     = HOLD;
            out_valid_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; led trails number by one cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      index     <= '0;
      count     <= '0;
      number    <= '1;
      led       <= '1;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      index     <= index_nxt;
      count     <= count_nxt;
      number    <= number_nxt;
      led       <= number;
      out_valid <= out_valid_nxt;
      ovf       <= ovf_nxt;
    end
  end

`ifdef ZERO_EXP_SELFCHECK_EN
  logic             chk_pend;
  logic [CNT_W-1:0] zeros;

  // Zero-bit count of the finished word.
  always_comb begin
    zeros = '0;
    for (int i = 0; i < WIDTH; i++) zeros = zeros + CNT_W'(!number[i]);
  end

  // Check once on the cycle after entering HOLD; the error is sticky until reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      chk_pend <= 1'b0;
      chk_err  <= 1'b0;
    end else begin
      chk_pend <= (state == BUILD) && (state_nxt == HOLD);
      if (chk_pend && (zeros != count)) chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_zero_count_expander.sv
// tb/tb_zero_count_expander.sv - directed self-checking bench for zero_count_expander
module tb_zero_count_expander;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] zero_count = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] number;
  logic [7:0] led;
  logic       ovf;
  logic       chk_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  zero_count_expander #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .zero_count(zero_count), .out_valid(out_valid), .out_ready(out_ready),
    .number(number), .led(led), .ovf(ovf), .chk_err(chk_err)
  );

  always #5 CLK = ~CLK;

  // Issue one request from a negedge; returns edges from acceptance to out_valid.
  // stall_at >= 0 drops enable for three edges after that many build edges.
  task automatic run_req(input logic [3:0] zc, input int stall_at, output int lat);
    zero_count = zc;
    in_valid   = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      if (stall_at >= 0 && lat == stall_at) enable = 1'b0;
      if (stall_at >= 0 && lat == stall_at + 3) enable = 1'b1;
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
  endtask

  // Release the held word and return to IDLE.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; enable = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low got %b exp 0", in_ready); else pass_cnt++;
    RST = 1'b1;
    @(negedge CLK);
    total_cnt++; if (number !== 8'hFF) $display("FAIL reset_number got %h exp ff", number); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0 || chk_err !== 1'b0) $display("FAIL reset_flags got ovf=%b chk=%b exp 0 0", ovf, chk_err); else pass_cnt++;
    total_cnt++; if (led !== 8'hFF) $display("FAIL reset_led got %h exp ff", led); else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    run_req(4'd3, -1, lat);
    total_cnt++; if (lat !== 8) $display("FAIL basic_latency got %0d exp 8", lat); else pass_cnt++;
    total_cnt++; if (number !== 8'hF8) $display("FAIL basic_number got %h exp f8", number); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %b exp 0", ovf); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_hold_in_ready got %b exp 0", in_ready); else pass_cnt++;
    in_valid = 1'b1; zero_count = 4'd7;
    @(posedge CLK); @(negedge CLK);
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || number !== 8'hF8) $display("FAIL hold_stable got v=%b n=%h exp 1 f8", out_valid, number); else pass_cnt++;
    total_cnt++; if (led !== 8'hF8) $display("FAIL basic_led got %h exp f8", led); else pass_cnt++;
    drain();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_drain got v=%b r=%b exp 0 1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_bounds();
    int lat;
    run_req(4'd0, -1, lat);
    total_cnt++; if (number !== 8'hFF) $display("FAIL zero0_number got %h exp ff", number); else pass_cnt++;
    drain();
    run_req(4'd8, -1, lat);
    total_cnt++; if (lat !== 8) $display("FAIL zero8_latency got %0d exp 8", lat); else pass_cnt++;
    total_cnt++; if (number !== 8'h00) $display("FAIL zero8_number got %h exp 00", number); else pass_cnt++;
    drain();
    run_req(4'd12, -1, lat);
    total_cnt++; if (number !== 8'h00) $display("FAIL clamp_number got %h exp 00", number); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b1) $display("FAIL clamp_ovf got %b exp 1", ovf); else pass_cnt++;
    drain();
    total_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf); else pass_cnt++;
    run_req(4'd1, -1, lat);
    total_cnt++; if (number !== 8'hFE) $display("FAIL one_number got %h exp fe", number); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL one_ovf got %b exp 0", ovf); else pass_cnt++;
    drain();
  endtask

  task automatic test_stall();
    int lat;
    run_req(4'd5, 2, lat);
    total_cnt++; if (lat !== 11) $display("FAIL stall_latency got %0d exp 11", lat); else pass_cnt++;
    total_cnt++; if (number !== 8'hE0) $display("FAIL stall_number got %h exp e0", number); else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    run_req(4'd6, -1, lat);
    total_cnt++; if (lat !== 8 || number !== 8'hC0) $display("FAIL b2b_word got lat=%0d n=%h exp 8 c0", lat, number); else pass_cnt++;
    @(posedge CLK); @(negedge CLK);
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b2b_release got v=%b r=%b exp 0 1", out_valid, in_ready); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    zero_count = 4'd2; in_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); @(negedge CLK);
    total_cnt++; if (number !== 8'hFF || out_valid !== 1'b0) $display("FAIL midrst_state got n=%h v=%b exp ff 0", number, out_valid); else pass_cnt++;
    RST = 1'b1;
    @(negedge CLK);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_idle got %b exp 1", in_ready); else pass_cnt++;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    total_cnt++; if (out_valid !== 1'b0 || number !== 8'hFF) $display("FAIL midrst_discard got v=%b n=%h exp 0 ff", out_valid, number); else pass_cnt++;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_basic();
    test_bounds();
    test_stall();
    test_back_to_back();
    total_cnt++; if (chk_err !== 1'b0) $display("FAIL chk_err got %b exp 0", chk_err); else pass_cnt++;
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/zero_count_expander.md
Name: zero_count_expander

Overview:
- Inverse of the zero-bit counter: takes a requested zero count and serially builds a WIDTH-bit word with exactly that many zero bits, packed into the LSBs; all remaining bits are one.
- Sits between the count/status path and the led/pattern driver.
- The word is built one bit per cycle by an explicit bit-index counter. The index is sized one bit wider than the bit index so that the terminal value WIDTH is representable and the build loop always terminates.
- valid/ready handshake on both input and output.

Parameters:
- WIDTH, 8, number of bits in the generated word (>=2).
- CNT_W, $clog2(WIDTH+1), width of the count and the bit index; must hold the value WIDTH (4 for WIDTH=8).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous active-low reset.
- enable  input  1  advance enable; low stalls BUILD only.
- in_valid  input  1  zero_count is valid.
- in_ready  output  1  block can accept a request.
- zero_count  input  CNT_W  requested number of zero bits.
- out_valid  output  1  number holds a completed word.
- out_ready  input  1  consumer accepts number.
- number  output  WIDTH  generated word.
- led  output  WIDTH  copy of number, registered.
- ovf  output  1  last accepted request exceeded WIDTH and was clamped.
- chk_err  output  1  self-check mismatch (see Optional Feature).

Behaviour:
- Reset: RST sampled low at a rising edge gives
  - state=IDLE, index=0, count=0;
  - number=all ones, led=all ones;
  - out_valid=0, ovf=0, chk_err=0.
  - in_ready is combinational and therefore low while RST is low.
- Reset mid-operation aborts BUILD/HOLD; the partial word is discarded.
- States: IDLE, BUILD, HOLD.
- IDLE:
  - in_ready = enable & RST.
  - On in_valid & in_ready:
    - count <= min(zero_count, WIDTH);
    - ovf <= (zero_count > WIDTH);
    - index <= 0; number <= all ones;
    - go to BUILD.
  - No other input changes state.
- BUILD, on each edge with enable=1:
  - number[index] <= (index < count) ? 0 : 1;
  - index <= index + 1.
  - When index == WIDTH-1, the same edge moves to HOLD and sets out_valid <= 1.
  - With enable=0, index and number hold.
  - Comparisons are unsigned at CNT_W bits; index never wraps.
- HOLD:
  - out_valid=1; number and led are stable.
  - On out_ready=1: out_valid <= 0, go to IDLE.
  - enable has no effect in HOLD.
- led <= number on every edge (1-cycle lag).
- Latency: request accepted at edge t → out_valid high after edge t+WIDTH, given enable held high. Each enable-low cycle in BUILD adds one cycle.
- Throughput: one word per WIDTH+2 cycles minimum, since in_ready is low in BUILD and HOLD.
- Boundary cases:
  - count=0 → all ones.
  - count=WIDTH → all zeros.
  - zero_count>WIDTH → treated as WIDTH, ovf=1.
  - ovf holds until the next acceptance.
  - in_valid during BUILD/HOLD is ignored; the source holds it.
  - out_ready before out_valid is ignored.

Optional Feature:
- Macro: ZERO_EXP_SELFCHECK_EN.
- With the macro defined:
  - on entry to HOLD, a registered checker counts the zero bits of number;
  - chk_err <= (zeros != count), sticky until reset.
  - The checker counter is also CNT_W wide.
- Without the macro: chk_err is tied 0 and no checker logic is present.

Test Plan:
- Reset with RST=0 for 2 cycles, then RST=1 → number=8'hFF, out_valid=0, in_ready=1 with enable=1.
- zero_count=3, enable=1, out_ready=1 → out_valid after 8 edges, number=8'hF8, led=8'hF8 one cycle later, ovf=0.
- zero_count=0 → number=8'hFF; then zero_count=8 → number=8'h00, with no hang at index 8.
- zero_count=12 → number=8'h00, ovf=1; next request zero_count=1 → number=8'hFE, ovf=0.
- zero_count=5 with enable low for 3 cycles mid-BUILD → out_valid after 11 edges, number=8'hE0.
- zero_count=2, drop RST after 4 BUILD cycles → IDLE, number=8'hFF, out_valid=0. With ZERO_EXP_SELFCHECK_EN defined, chk_err stays 0 across all the above.
